// File: rtl/rgb_compositor_pkg.sv
// Shared types and constants for the VGA colour compositor.
// Optional border outline is enabled with RGB_COMPOSITOR_BORDER_EN.
package vga_comp_pkg;

    typedef enum logic [1:0] {
        S_FADE_IN  = 2'd0,
        S_HOLD     = 2'd1,
        S_FADE_OUT = 2'd2,
        S_OFF      = 2'd3
    } fade_st_t;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int LEVEL_MAX = 16;

    localparam int R_HI = 11;
    localparam int R_LO = 8;
    localparam int G_HI = 7;
    localparam int G_LO = 4;
    localparam int B_HI = 3;
    localparam int B_LO = 0;

    // 4b channel times 0..16 level; level 16 reproduces the channel exactly
    function automatic logic [3:0] fade_ch(
        input logic [3:0] ch,
        input logic [4:0] lvl
    );
        return 4'(({4'd0, ch} * {3'd0, lvl}) >> 4);
    endfunction

endpackage

// File: rtl/rgb_compositor_if.sv
// Pixel bus bundle between the timing/hit logic and the compositor.
// Master drives pixel inputs; slave returns the composited VGA pins.
interface rgb_compositor_if;

    logic       pix_stb;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [8:0] y;
    logic       animate;
    logic [2:0] layer;
    logic       fade_en;

    logic       out_hs;
    logic       out_vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [4:0] level;

    modport master (
        output pix_stb, hs, vs, x, y, animate, layer, fade_en,
        input  out_hs, out_vs, r, g, b, level
    );

    modport slave (
        input  pix_stb, hs, vs, x, y, animate, layer, fade_en,
        output out_hs, out_vs, r, g, b, level
    );

endinterface

// File: rtl/rgb_compositor_fade_ctrl.sv
// Frame-based brightness fade sequencer: fade in, hold, fade out, off.
// All state moves only on the end-of-frame event.
module fade_ctrl
    import vga_comp_pkg::*;
#(
    parameter int FADE_DIV    = 2,
    parameter int HOLD_FRAMES = 120,
    parameter int OFF_FRAMES  = 30
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ev,
    input  logic       i_fade_en,
    output logic [4:0] o_level
);

    localparam logic [7:0] DIV_M1 = 8'(FADE_DIV - 1);
    localparam logic [7:0] HOLD_N = 8'(HOLD_FRAMES);
    localparam logic [7:0] OFF_N  = 8'(OFF_FRAMES);
    localparam logic [4:0] LV_TOP = 5'(LEVEL_MAX);

    fade_st_t   r_st;
    logic [7:0] r_cnt;
    logic [4:0] r_lvl;

    logic [7:0] w_cnt_inc;
    logic       w_div_hit;

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_div_hit = (r_cnt == DIV_M1);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_st  <= S_FADE_IN;
            r_cnt <= 8'd0;
            r_lvl <= 5'd0;
        end else if (i_ev) begin
            // disable overrides any transition due on this frame
            if (!i_fade_en) begin
                r_st  <= S_HOLD;
                r_cnt <= 8'd0;
                r_lvl <= LV_TOP;
            end else begin
                unique case (r_st)
                    S_FADE_IN: begin
                        if (w_div_hit) begin
                            r_cnt <= 8'd0;
                            r_lvl <= r_lvl + 5'd1;
                            if (r_lvl == LV_TOP - 5'd1)
                                r_st <= S_HOLD;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_HOLD: begin
                        if (w_cnt_inc == HOLD_N) begin
                            r_st  <= S_FADE_OUT;
                            r_cnt <= 8'd0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_FADE_OUT: begin
                        if (w_div_hit) begin
                            r_cnt <= 8'd0;
                            r_lvl <= r_lvl - 5'd1;
                            if (r_lvl == 5'd1)
                                r_st <= S_OFF;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_OFF: begin
                        if (w_cnt_inc == OFF_N) begin
                            r_st  <= S_FADE_IN;
                            r_cnt <= 8'd0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_st  <= S_FADE_IN;
                        r_cnt <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign o_level = r_lvl;

endmodule

// File: rtl/rgb_compositor.sv
// Two-stage VGA output compositor: layer priority, blanking, fade.
// Define RGB_COMPOSITOR_BORDER_EN for a white outline on the active edge.
module rgb_compositor
    import vga_comp_pkg::*;
#(
    parameter logic [11:0] L0_RGB      = 12'hF00,
    parameter logic [11:0] L1_RGB      = 12'h0F0,
    parameter logic [11:0] L2_RGB      = 12'h00F,
    parameter logic [11:0] BG_RGB      = 12'h000,
    parameter int          FADE_DIV    = 2,
    parameter int          HOLD_FRAMES = 120,
    parameter int          OFF_FRAMES  = 30
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic       i_hs,
    input  logic       i_vs,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic       i_animate,
    input  logic [2:0] i_layer,
    input  logic       i_fade_en,
    output logic       o_hs,
    output logic       o_vs,
    output logic [3:0] o_r,
    output logic [3:0] o_g,
    output logic [3:0] o_b,
    output logic [4:0] o_level
);

    logic [2:0] r_s1_layer;
    logic       r_s1_hs;
    logic       r_s1_vs;
    logic       r_s1_act;

    logic       r_hs;
    logic       r_vs;
    logic [3:0] r_r;
    logic [3:0] r_g;
    logic [3:0] r_b;

    logic        w_ev;
    logic        w_act;
    logic [4:0]  w_level;
    logic [11:0] w_rgb;
    logic [3:0]  w_r;
    logic [3:0]  w_g;
    logic [3:0]  w_b;

    assign w_ev  = i_animate & i_pix_stb;
    assign w_act = (i_x < 10'(H_ACTIVE)) && (i_y < 9'(V_ACTIVE));

    fade_ctrl #(
        .FADE_DIV    (FADE_DIV),
        .HOLD_FRAMES (HOLD_FRAMES),
        .OFF_FRAMES  (OFF_FRAMES)
    ) u_fade (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_ev      (w_ev),
        .i_fade_en (i_fade_en),
        .o_level   (w_level)
    );

`ifdef RGB_COMPOSITOR_BORDER_EN
    logic r_s1_edge;
    logic w_edge;

    assign w_edge = (i_x == 10'd0) || (i_x == 10'(H_ACTIVE - 1)) ||
                    (i_y == 9'd0)  || (i_y == 9'(V_ACTIVE - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst)
            r_s1_edge <= 1'b0;
        else if (i_pix_stb)
            r_s1_edge <= w_edge;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_s1_layer <= 3'd0;
            r_s1_hs    <= 1'b1;
            r_s1_vs    <= 1'b1;
            r_s1_act   <= 1'b0;
        end else if (i_pix_stb) begin
            r_s1_layer <= i_layer;
            r_s1_hs    <= i_hs;
            r_s1_vs    <= i_vs;
            r_s1_act   <= w_act;
        end
    end

    always_comb begin
        w_rgb = BG_RGB;
        if (r_s1_layer[0])
            w_rgb = L0_RGB;
        else if (r_s1_layer[1])
            w_rgb = L1_RGB;
        else if (r_s1_layer[2])
            w_rgb = L2_RGB;

        w_r = fade_ch(w_rgb[R_HI:R_LO], w_level);
        w_g = fade_ch(w_rgb[G_HI:G_LO], w_level);
        w_b = fade_ch(w_rgb[B_HI:B_LO], w_level);

        // blanking wins over everything, border wins over layers and fade
        if (!r_s1_act) begin
            w_r = 4'h0;
            w_g = 4'h0;
            w_b = 4'h0;
        end
`ifdef RGB_COMPOSITOR_BORDER_EN
        else if (r_s1_edge) begin
            w_r = 4'hF;
            w_g = 4'hF;
            w_b = 4'hF;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hs <= 1'b1;
            r_vs <= 1'b1;
            r_r  <= 4'h0;
            r_g  <= 4'h0;
            r_b  <= 4'h0;
        end else if (i_pix_stb) begin
            r_hs <= r_s1_hs;
            r_vs <= r_s1_vs;
            r_r  <= w_r;
            r_g  <= w_g;
            r_b  <= w_b;
        end
    end

    assign o_hs    = r_hs;
    assign o_vs    = r_vs;
    assign o_r     = r_r;
    assign o_g     = r_g;
    assign o_b     = r_b;
    assign o_level = w_level;

endmodule

// File: tb/tb_rgb_compositor.sv
// Scoreboard bench for rgb_compositor: directed pixels and fade frames.
`timescale 1ns/1ps
module tb_rgb_compositor;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } px_t;

    logic clk = 1'b0;
    logic rst;

    rgb_compositor_if vif ();

    always #5 clk = ~clk;

    rgb_compositor #(
        .FADE_DIV    (2),
        .HOLD_FRAMES (3),
        .OFF_FRAMES  (1)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_pix_stb (vif.pix_stb),
        .i_hs      (vif.hs),
        .i_vs      (vif.vs),
        .i_x       (vif.x),
        .i_y       (vif.y),
        .i_animate (vif.animate),
        .i_layer   (vif.layer),
        .i_fade_en (vif.fade_en),
        .o_hs      (vif.out_hs),
        .o_vs      (vif.out_vs),
        .o_r       (vif.r),
        .o_g       (vif.g),
        .o_b       (vif.b),
        .o_level   (vif.level)
    );

    px_t q[$];
    int  checks = 0;
    int  errors = 0;

    logic edge_stb = 1'b0;
    logic edge_rst = 1'b0;
    px_t  prev = '0;

    always @(posedge clk) begin
        edge_stb = vif.pix_stb;
        edge_rst = rst;
    end

    // monitor: pops one expectation per strobe, and checks hold between strobes
    always @(negedge clk) begin
        px_t act;
        px_t e;
        act = '{vif.out_hs, vif.out_vs, vif.r, vif.g, vif.b};
        if (rst === 1'b1) begin
            if (vif.pix_stb) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: output %h with no expectation", act);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL pixel: got hs=%b vs=%b rgb=%h%h%h, want hs=%b vs=%b rgb=%h%h%h",
                                 act.hs, act.vs, act.r, act.g, act.b,
                                 e.hs, e.vs, e.r, e.g, e.b);
                    end
                end
            end else if (!edge_stb && edge_rst) begin
                checks++;
                if (act !== prev) begin
                    errors++;
                    $display("FAIL hold_no_strobe: got %h, want %h", act, prev);
                end
            end
        end
        prev = act;
    end

    task automatic pix(input int x, input int y, input logic [2:0] layer,
                       input logic hs, input logic vs, input logic anim,
                       input logic [3:0] er, input logic [3:0] eg,
                       input logic [3:0] eb);
        @(posedge clk);
        #1;
        vif.x       = x[9:0];
        vif.y       = y[8:0];
        vif.layer   = layer;
        vif.hs      = hs;
        vif.vs      = vs;
        vif.animate = anim;
        vif.pix_stb = 1'b1;
        q.push_back('{hs, vs, er, eg, eb});
        @(posedge clk);
        #1;
        vif.pix_stb = 1'b0;
        vif.animate = 1'b0;
    endtask

    // end-of-frame strobe on a blanked pixel so its colour is level-independent
    task automatic ev();
        pix(700, 10, 3'b001, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic chk_lvl(input int exp, input string nm);
        checks++;
        if (vif.level !== exp[4:0]) begin
            errors++;
            $display("FAIL %s: level got %0d, want %0d", nm, vif.level, exp);
        end
    endtask

    task automatic chk_blank(input string nm);
        checks++;
        if (vif.out_hs !== 1'b1 || vif.out_vs !== 1'b1 ||
            vif.r !== 4'h0 || vif.g !== 4'h0 || vif.b !== 4'h0 ||
            vif.level !== 5'd0) begin
            errors++;
            $display("FAIL %s: got hs=%b vs=%b rgb=%h%h%h lvl=%0d, want 1 1 000 0",
                     nm, vif.out_hs, vif.out_vs, vif.r, vif.g, vif.b, vif.level);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        q.push_back('{1'b1, 1'b1, 4'h0, 4'h0, 4'h0});
        q.push_back('{1'b1, 1'b1, 4'h0, 4'h0, 4'h0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        vif.pix_stb = 1'b0;
        vif.hs      = 1'b1;
        vif.vs      = 1'b1;
        vif.x       = '0;
        vif.y       = '0;
        vif.animate = 1'b0;
        vif.layer   = '0;
        vif.fade_en = 1'b1;

        do_reset();
        chk_blank("reset_state");
        rst = 1'b1;

        // sync alignment at level 0: colour stays black
        pix(100, 100, 3'b001, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(100, 100, 3'b001, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(100, 100, 3'b010, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(100, 100, 3'b100, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(100, 100, 3'b000, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        chk_lvl(0, "level_after_reset");

        // animate without a strobe is not a frame event
        @(posedge clk);
        #1;
        vif.animate = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vif.animate = 1'b0;
        chk_lvl(0, "animate_no_stb");

        for (int n = 1; n <= 125; n++) begin
            ev();
            case (n)
                1:   chk_lvl(0,  "ev1");
                2:   chk_lvl(1,  "ev2");
                16: begin
                    chk_lvl(8, "ev16");
                    pix(100, 100, 3'b001, 1'b1, 1'b1, 1'b0, 4'h7, 4'h0, 4'h0);
                    pix(100, 100, 3'b010, 1'b1, 1'b1, 1'b0, 4'h0, 4'h7, 4'h0);
                end
                31:  chk_lvl(15, "ev31");
                32: begin
                    chk_lvl(16, "ev32");
                    pix(100, 100, 3'b001, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0);
                end
                34:  chk_lvl(16, "ev34_hold");
                35:  chk_lvl(16, "ev35_fade_out");
                36:  chk_lvl(16, "ev36");
                37:  chk_lvl(15, "ev37");
                66:  chk_lvl(1,  "ev66");
                67:  chk_lvl(0,  "ev67_off");
                68:  chk_lvl(0,  "ev68_fade_in");
                69:  chk_lvl(0,  "ev69");
                70:  chk_lvl(1,  "ev70");
                100: chk_lvl(16, "ev100");
                103: chk_lvl(16, "ev103");
                105: chk_lvl(15, "ev105");
                125: begin
                    chk_lvl(5, "ev125");
                    pix(100, 100, 3'b100, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h4);
                end
                default: ;
            endcase
        end

        // disable mid fade-out: jump to full brightness and hold
        vif.fade_en = 1'b0;
        ev();
        chk_lvl(16, "disable_jump");
        for (int k = 0; k < 10; k++) begin
            ev();
            chk_lvl(16, "disabled_hold");
        end

        vif.fade_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            ev();
            chk_lvl((k == 5) ? 15 : 16, "reenable");
        end

        vif.fade_en = 1'b0;
        ev();
        chk_lvl(16, "disable_again");

        // priority and blanking at full brightness
        pix(100, 100, 3'b111, 1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0);
        pix(100, 100, 3'b110, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 4'h0);
        pix(100, 100, 3'b100, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF);
        pix(100, 100, 3'b000, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(640, 10,  3'b001, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(5,   480, 3'b001, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(639, 479, 3'b010, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h0);
        pix(0,   0,   3'b001, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0);
        pix(700, 10,  3'b000, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(700, 10,  3'b000, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);

        // reset with a coloured pixel in flight
        pix(100, 100, 3'b001, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0);
        do_reset();
        chk_blank("mid_reset");
        rst = 1'b1;
        pix(100, 100, 3'b001, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(100, 100, 3'b001, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(700, 10,  3'b000, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        pix(700, 10,  3'b000, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_compositor.md
Name: rgb_compositor

Overview:
- Pixel output stage between the 640x480 timing generator / square hit logic and the VGA pins.
- Takes per-pixel layer hit bits, timing position and syncs. Applies priority compositing, active-area blanking and a frame-based brightness fade.
- Drives 4-bit R/G/B with sync delayed to match, so colour and sync stay aligned.

Parameters:
- L0_RGB, 12'hF00, colour of layer 0 (highest priority), {R,G,B} 4 bits each.
- L1_RGB, 12'h0F0, colour of layer 1.
- L2_RGB, 12'h00F, colour of layer 2 (lowest priority).
- BG_RGB, 12'h000, background colour inside the active area.
- FADE_DIV, 2, frames per fade level step; legal range 1..255.
- HOLD_FRAMES, 120, frames held at full brightness; legal range 1..255.
- OFF_FRAMES, 30, frames held at level 0; legal range 1..255.

Ports:
- i_clk  in  1  system clock (100 MHz).
- i_rst  in  1  reset; synchronous, active-low.
- i_pix_stb  in  1  pixel strobe; the pipeline advances only when this is high.
- i_hs  in  1  horizontal sync from the timing generator (active-low).
- i_vs  in  1  vertical sync from the timing generator (active-low).
- i_x  in  10  pixel x position.
- i_y  in  9  pixel y position.
- i_animate  in  1  end-of-active-frame pulse.
- i_layer  in  3  layer hit bits; bit0 = layer 0.
- i_fade_en  in  1  enables the fade sequence.
- o_hs  out  1  delayed horizontal sync.
- o_vs  out  1  delayed vertical sync.
- o_r  out  4  red.
- o_g  out  4  green.
- o_b  out  4  blue.
- o_level  out  5  current fade level, 0..16.

Behaviour:
- Reset (i_rst=0 at a clock edge): o_hs=1, o_vs=1, o_r/o_g/o_b=0, o_level=0, FSM=S_FADE_IN, frame counter=0, pipeline registers cleared to blank with syncs at 1.
- Pipeline: 2 stages, each enabled by i_pix_stb. All outputs (colour and sync) lag their inputs by exactly 2 strobes. No change on non-strobe cycles.
- Stage 1 registers:
  - i_layer, i_hs, i_vs.
  - active = (i_x < 640) && (i_y < 480).
- Stage 2 compositing:
  - Colour chosen by priority: L0 > L1 > L2 > BG.
  - Inactive pixels output 0 regardless of layer bits.
  - Each channel is faded as out = (ch * level) >> 4. This is a 4b x 5b product (9b), shifted, fitting 4b; level 16 gives out = ch exactly.
- Fade event: ev = i_animate & i_pix_stb. Level and state change only on ev, never mid-frame.
- Fade FSM, frame counter cnt (8b):
  - S_FADE_IN: on ev, cnt++; when cnt == FADE_DIV-1, level++ and cnt=0. On the ev where level reaches 16, go to S_HOLD with cnt=0.
  - S_HOLD: on ev, cnt++; on the ev where cnt reaches HOLD_FRAMES, go to S_FADE_OUT with cnt=0.
  - S_FADE_OUT: mirror of S_FADE_IN, counting level down. On the ev where level reaches 0, go to S_OFF with cnt=0.
  - S_OFF: after OFF_FRAMES events, go to S_FADE_IN with cnt=0.
- i_fade_en=0: at the next ev, level=16, state=S_HOLD, cnt=0. The FSM stays held there while i_fade_en=0. Re-enabling resumes from S_HOLD with cnt=0.
- i_fade_en sampled low on the same ev as a pending transition: the disable wins.
- o_level is the registered level. It changes on the ev cycle and first affects the pixel that reaches stage 2 on the following strobe.
- Reset mid-frame takes effect at the next edge. Outputs blank with syncs high until 2 strobes after reset release.

Optional Feature:
- Macro: RGB_COMPOSITOR_BORDER_EN.
- Defined: active pixels with x==0, x==639, y==0 or y==479 output 12'hFFF at full brightness. This overrides layers and fade, and is still subject to blanking.
- Undefined: no border logic; edge pixels composite normally.

Decomposition:
- Package vga_comp_pkg holds:
  - Fade state enum: S_FADE_IN, S_HOLD, S_FADE_OUT, S_OFF.
  - H_ACTIVE=640, V_ACTIVE=480, LEVEL_MAX=16.
  - RGB12 channel slice helpers (constants for bit ranges).
- One sub-module, fade_ctrl, contains the FSM plus counter. Inputs are clk, rst, ev and fade_en; the output is level. It lives inside rgb_compositor.

Test Plan:
- Reset, then release; drive i_hs=0 at strobe N -> o_hs=0 exactly at strobe N+2; o_r/g/b=0 and o_level=0 until fade starts.
- i_fade_en=0, one ev, then i_layer=3'b111 at x=100,y=100 -> RGB=F,0,0 after 2 strobes; i_layer=3'b110 -> 0,F,0; i_layer=3'b000 -> BG 0,0,0.
- i_layer=3'b001 at x=640,y=10 and at x=5,y=480 -> RGB=0,0,0 (blanked).
- FADE_DIV=2, HOLD_FRAMES=3, OFF_FRAMES=1 -> o_level=1 after 2 ev, 16 after 32 ev; S_FADE_OUT entered at ev 35; o_level=0 at ev 67; level steps up again starting ev 68.
- Level 8 with L0=F -> o_r=7 (15*8>>4); level 16 -> o_r=15.
- i_fade_en dropped during S_FADE_OUT at level 5 -> next ev o_level=16, held across 10 ev; re-enable -> S_FADE_OUT entered 3 ev later (HOLD_FRAMES=3).
